// File: rtl/wb_reg_file.sv
// Y86-64 architectural register file with halt latch and retire counter.
// Optional write-through read bypass: define REGFILE_BYPASS_EN.
module wb_reg_file #(
    parameter logic [63:0] RSP_INIT = 64'd0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       W_stat,
    input  logic [3:0]       W_icode,
    input  logic [3:0]       W_dstE,
    input  logic [63:0]      W_valE,
    input  logic [3:0]       W_dstM,
    input  logic [63:0]      W_valM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    output logic [63:0]      d_rvalA,
    output logic [63:0]      d_rvalB,
    input  logic [3:0]       dbg_sel,
    output logic [63:0]      dbg_val,
    output logic             halted,
    output logic [1:0]       halt_stat,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] RNONE  = 4'hF;
    localparam logic [3:0] I_NOP  = 4'd1;
    localparam logic [1:0] S_AOK  = 2'd0;

    logic [63:0] regs [0:14];
    logic        wr_ok;
    logic        wr_e;
    logic        wr_m;

    assign wr_ok = (W_stat == S_AOK) && !halted;
    // On an E/M address collision the M value wins (popq %rsp).
    assign wr_m  = wr_ok && (W_dstM != RNONE);
    assign wr_e  = wr_ok && (W_dstE != RNONE) && (W_dstE != W_dstM);

    function automatic logic [63:0] rd(input logic [3:0] a);
        logic [63:0] v;
        v = (a == RNONE) ? 64'd0 : regs[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && a != RNONE) begin
            if (a == W_dstE) v = W_valE;
            if (a == W_dstM) v = W_valM;
        end
`endif
        return v;
    endfunction

    assign d_rvalA = rd(d_srcA);
    assign d_rvalB = rd(d_srcB);
    assign dbg_val = rd(dbg_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) begin
                regs[i] <= (i == 4) ? RSP_INIT : 64'd0;
            end
        end else begin
            if (wr_e) regs[W_dstE] <= W_valE;
            if (wr_m) regs[W_dstM] <= W_valM;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted    <= 1'b0;
            halt_stat <= 2'd0;
        end else if (!halted && W_stat != S_AOK) begin
            halted    <= 1'b1;
            halt_stat <= W_stat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_count <= '0;
        end else if (wr_ok && W_icode != I_NOP) begin
            instr_count <= instr_count + 1'b1;
        end
    end

endmodule

// File: doc/wb_reg_file.md
Name: wb_reg_file

Overview:
- Architectural register file for the Y86-64 pipeline: the receiving end of the write-back stage's W_dstE/W_valE and W_dstM/W_valM write traffic, and the source of operands for decode via srcA/srcB read ports.
- Also owns retirement bookkeeping:
  - sticky halt/exception status, taken from W_stat;
  - retired-instruction counter;
  - a debug read port for benches.

Parameters:
- RSP_INIT, 64'd0, reset value of %rsp (reg 4).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- W_stat  in  2  status of the instruction in W: 0=AOK, 1=HLT, 2=ADR, 3=INS.
- W_icode  in  4  icode in W; 4'd1 (nop/bubble) is not counted.
- W_dstE  in  4  E write address; 4'hF = RNONE (no write).
- W_valE  in  64  E write data.
- W_dstM  in  4  M write address; 4'hF = RNONE.
- W_valM  in  64  M write data.
- d_srcA  in  4  read address A from decode.
- d_srcB  in  4  read address B from decode.
- d_rvalA  out  64  combinational read data A.
- d_rvalB  out  64  combinational read data B.
- dbg_sel  in  4  debug read address.
- dbg_val  out  64  combinational debug read data.
- halted  out  1  sticky: a non-AOK W_stat has been seen.
- halt_stat  out  2  W_stat captured when halted first set.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Storage: 15 x 64-bit registers, indices 0..14. Index 15 (RNONE) is never stored.
- Reset (async, immediate, independent of clk):
  - regs 0..3 and 5..14 = 0; reg 4 = RSP_INIT;
  - halted = 0, halt_stat = 0, instr_count = 0.
- Reads are combinational:
  - d_rvalA = reg[d_srcA]; d_rvalB = reg[d_srcB]; dbg_val = reg[dbg_sel];
  - address 15 returns 64'd0.
- Write enable:
  - wr_ok = (W_stat == 0) && !halted.
  - On posedge with wr_ok: if W_dstE != 15, reg[W_dstE] <= W_valE; if W_dstM != 15, reg[W_dstM] <= W_valM.
- Same-address collision (W_dstE == W_dstM != 15): only W_valM is written (popq %rsp rule).
- Halt latch:
  - On posedge, if !halted and W_stat != 0: halted <= 1, halt_stat <= W_stat.
  - No register writes occur in that cycle.
  - While halted, all writes and counting are frozen until reset.
- Counter:
  - On posedge, if wr_ok and W_icode != 4'd1: instr_count <= instr_count + 1.
  - Wraps modulo 2^CNT_W with no saturation.
- Latency: a write issued at edge N is visible on the read ports right after edge N (same-cycle visibility is governed by the optional feature below).
- Reset asserted mid-operation clears all state immediately. The first edge after deassertion behaves normally.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: the read ports use write-through bypass. If wr_ok and a read address (not 15) matches a pending write address in the same cycle, the read returns the pending data. W_valM takes priority over W_valE on a double match. Same bypass applies to d_rvalA, d_rvalB and dbg_val.
- Undefined: reads return only stored contents. The pipeline relies on decode forwarding for same-cycle values.

Test Plan:
- Reset with RSP_INIT=64'h100 -> dbg_sel=4 reads 64'h100; all other indices read 0; instr_count=0; halted=0.
- W_stat=0, W_icode=3, W_dstE=0, W_valE=64'd42, W_dstM=15, one edge -> d_srcA=0 reads 42; instr_count=1.
- W_dstE=W_dstM=4, W_valE=64'hF8, W_valM=64'h55 -> reg4 = 64'h55.
- W_icode=1 with W_dstE=15 for 3 edges -> no register change; instr_count unchanged.
- W_stat=1 (HLT) with W_dstE=2, W_valE=7 -> reg2 stays 0; halted=1, halt_stat=1. Next edge with W_stat=0 and a write to reg2 -> still ignored. Async reset mid-cycle -> halted=0 immediately.
- With REGFILE_BYPASS_EN: W_dstE=3, W_valE=9, d_srcB=3 before the edge -> d_rvalB=9. Without the macro -> d_rvalB=0 until after the edge.
